// File: rtl/spio_hss_multiplexer_pkt_sched_pkg.sv
// Shared definitions for the SpiNNaker HSS multiplexer transmit-side packet scheduler.
// Also provides the PKT_BITS packet width macro to every file compiled after this one.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif

package spio_hss_multiplexer_pkt_sched_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_ARB  = 2'd1,
        SCHED_XFER = 2'd2
    } sched_state_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/spio_hss_multiplexer_rr_arb.sv
// Combinational round-robin arbiter: the winner is the first request at or
// above rr_ptr+1, modulo N. N must be a power of two so the index wraps naturally.
module spio_hss_multiplexer_rr_arb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id
);

    // Scan from lowest to highest priority so the closest request overwrites the rest.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[rr_ptr + W'(i)]) begin
                gnt    = N'(1) << (rr_ptr + W'(i));
                gnt_id = rr_ptr + W'(i);
            end
        end
    end

endmodule

// File: rtl/spio_hss_multiplexer_pkt_sched.sv
// Transmit-side frame scheduler: pops up to MAX_PKTS packets per frame round-robin
// from eligible FIFOs. Optional grant counters under SPIO_HSS_SCHED_STATS_EN.
module spio_hss_multiplexer_pkt_sched
    import spio_hss_multiplexer_pkt_sched_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CH_BITS  = 2,
    parameter int PKT_W    = `PKT_BITS,
    parameter int MAX_PKTS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frm_req,
    output logic                    frm_done,
    output logic                    frm_empty,
    input  logic [NUM_CH-1:0]       ch_vld,
    input  logic [NUM_CH*PKT_W-1:0] ch_data,
    output logic [NUM_CH-1:0]       ch_rdy,
    input  logic [NUM_CH-1:0]       rcfc,
    output logic [PKT_W-1:0]        pkt_data,
    output logic [CH_BITS-1:0]      pkt_ch,
    output logic                    pkt_vld,
    input  logic                    pkt_rdy
`ifdef SPIO_HSS_SCHED_STATS_EN
    ,
    input  logic [CH_BITS-1:0]      stat_sel,
    input  logic                    stat_clr,
    output logic [STAT_W-1:0]       stat_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_PKTS + 1);

    sched_state_t       state, state_nxt;
    logic [CH_BITS-1:0] rr_ptr;
    logic [CNT_W-1:0]   pkt_cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cnt_last;
    logic [NUM_CH-1:0]  eligible;
    logic [NUM_CH-1:0]  gnt;
    logic [CH_BITS-1:0] gnt_id;

    assign eligible = ch_vld & rcfc;
    assign cnt_inc  = pkt_cnt + CNT_W'(1);
    assign cnt_last = (cnt_inc == CNT_W'(MAX_PKTS));

    spio_hss_multiplexer_rr_arb #(
        .N (NUM_CH),
        .W (CH_BITS)
    ) u_arb (
        .req    (eligible),
        .rr_ptr (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SCHED_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ch_rdy    = '0;
        case (state)
            SCHED_IDLE: if (frm_req) state_nxt = SCHED_ARB;
            SCHED_ARB: begin
                if (|eligible) begin
                    ch_rdy    = gnt;
                    state_nxt = SCHED_XFER;
                end else begin
                    state_nxt = SCHED_IDLE;
                end
            end
            SCHED_XFER: if (pkt_rdy) state_nxt = cnt_last ? SCHED_IDLE : SCHED_ARB;
            default:    state_nxt = SCHED_IDLE;
        endcase
    end

    // The popped FIFO entry lives only in pkt_data; inputs are not looked at again until ARB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_data  <= '0;
            pkt_ch    <= '0;
            pkt_vld   <= 1'b0;
            rr_ptr    <= CH_BITS'(NUM_CH - 1);
            pkt_cnt   <= '0;
            frm_done  <= 1'b0;
            frm_empty <= 1'b0;
        end else begin
            frm_done  <= 1'b0;
            frm_empty <= 1'b0;
            case (state)
                SCHED_IDLE: if (frm_req) pkt_cnt <= '0;
                SCHED_ARB: begin
                    if (|eligible) begin
                        pkt_data <= ch_data[gnt_id*PKT_W +: PKT_W];
                        pkt_ch   <= gnt_id;
                        pkt_vld  <= 1'b1;
                        rr_ptr   <= gnt_id;
                    end else if (pkt_cnt == '0) begin
                        frm_empty <= 1'b1;
                    end else begin
                        frm_done <= 1'b1;
                    end
                end
                SCHED_XFER: begin
                    if (pkt_rdy) begin
                        pkt_vld <= 1'b0;
                        pkt_cnt <= cnt_inc;
                        if (cnt_last) frm_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPIO_HSS_SCHED_STATS_EN
    logic [NUM_CH-1:0][STAT_W-1:0] grant_cnt;

    // Clear has priority over a same-cycle grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (stat_clr) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (ch_rdy[i] && grant_cnt[i] != {STAT_W{1'b1}})
                    grant_cnt[i] <= grant_cnt[i] + STAT_W'(1);
        end
    end

    assign stat_cnt = grant_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_spio_hss_multiplexer_pkt_sched.sv
// Directed self-checking bench for the HSS multiplexer packet scheduler.
module tb_spio_hss_multiplexer_pkt_sched;

    localparam int NUM_CH = 4;
    localparam int CH_BITS = 2;
    localparam int PKT_W = 72;
    localparam int MAX_PKTS = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    frm_req;
    logic                    frm_done;
    logic                    frm_empty;
    logic [NUM_CH-1:0]       ch_vld;
    logic [NUM_CH*PKT_W-1:0] ch_data;
    logic [NUM_CH-1:0]       ch_rdy;
    logic [NUM_CH-1:0]       rcfc;
    logic [PKT_W-1:0]        pkt_data;
    logic [CH_BITS-1:0]      pkt_ch;
    logic                    pkt_vld;
    logic                    pkt_rdy;
`ifdef SPIO_HSS_SCHED_STATS_EN
    logic [CH_BITS-1:0]      stat_sel;
    logic                    stat_clr;
    logic [15:0]             stat_cnt;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    spio_hss_multiplexer_pkt_sched #(
        .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .PKT_W(PKT_W), .MAX_PKTS(MAX_PKTS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frm_req(frm_req), .frm_done(frm_done),
        .frm_empty(frm_empty), .ch_vld(ch_vld), .ch_data(ch_data), .ch_rdy(ch_rdy),
        .rcfc(rcfc), .pkt_data(pkt_data), .pkt_ch(pkt_ch), .pkt_vld(pkt_vld),
        .pkt_rdy(pkt_rdy)
`ifdef SPIO_HSS_SCHED_STATS_EN
        , .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
    );

    function automatic logic [PKT_W-1:0] pat(int ch, int k);
        return {8'hC0 + 8'(ch), 32'hDEAD_BEEF, 24'h0, 8'(k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(int k);
        for (int i = 0; i < NUM_CH; i++) ch_data[i*PKT_W +: PKT_W] = pat(i, k);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frm_req = 1'b0; ch_vld = '0; rcfc = '0; pkt_rdy = 1'b0;
        set_data(0);
`ifdef SPIO_HSS_SCHED_STATS_EN
        stat_sel = '0; stat_clr = 1'b0;
`endif
        tick(); tick();
        vecs++;
        if ({pkt_vld, frm_done, frm_empty, ch_rdy, pkt_ch} !== 9'd0 || pkt_data !== '0) begin
            errs++;
            $display("FAIL reset_outputs: vld=%b done=%b empty=%b rdy=%b ch=%0d data=%h, required all 0",
                     pkt_vld, frm_done, frm_empty, ch_rdy, pkt_ch, pkt_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_empty();
        ch_vld = '0; rcfc = '1; frm_req = 1'b1;
        tick();
        frm_req = 1'b0;
        vecs++;
        if (ch_rdy !== 4'b0000 || frm_empty !== 1'b0) begin
            errs++; $display("FAIL empty_arb: rdy=%b empty=%b, required 0000/0", ch_rdy, frm_empty);
        end
        tick();
        vecs++;
        if (frm_empty !== 1'b1 || frm_done !== 1'b0 || pkt_vld !== 1'b0) begin
            errs++; $display("FAIL empty_pulse: empty=%b done=%b vld=%b, required 1/0/0", frm_empty, frm_done, pkt_vld);
        end
        tick();
        vecs++;
        if (frm_empty !== 1'b0) begin
            errs++; $display("FAIL empty_one_cycle: empty=%b, required 0", frm_empty);
        end
    endtask

    // Runs a full frame with every channel valid; exp lists expected winners.
    task automatic run_frame(string name, input int exp [4]);
        pkt_rdy = 1'b1; frm_req = 1'b1;
        tick();
        frm_req = 1'b0;
        for (int k = 0; k < MAX_PKTS; k++) begin
            vecs++;
            if (ch_rdy !== 4'(1 << exp[k])) begin
                errs++; $display("FAIL %s_rdy%0d: rdy=%b, required %b", name, k, ch_rdy, 4'(1 << exp[k]));
            end
            tick();
            vecs++;
            if (pkt_vld !== 1'b1 || pkt_ch !== 2'(exp[k]) || pkt_data !== pat(exp[k], 0)) begin
                errs++; $display("FAIL %s_pkt%0d: vld=%b ch=%0d data=%h, required 1/%0d/%h",
                                 name, k, pkt_vld, pkt_ch, pkt_data, exp[k], pat(exp[k], 0));
            end
            tick();
        end
        vecs++;
        if (frm_done !== 1'b1 || frm_empty !== 1'b0 || pkt_vld !== 1'b0) begin
            errs++; $display("FAIL %s_done: done=%b empty=%b vld=%b, required 1/0/0", name, frm_done, frm_empty, pkt_vld);
        end
    endtask

    task automatic test_round_robin();
        ch_vld = '1; rcfc = '1; set_data(0);
        run_frame("rr_f0", '{0, 1, 2, 3});
        run_frame("rr_f1", '{0, 1, 2, 3});
    endtask

    task automatic test_rcfc_mask();
        ch_vld = '1; rcfc = 4'b1010;
        run_frame("rcfc", '{1, 3, 1, 3});
    endtask

    task automatic test_single();
        ch_vld = 4'b0100; rcfc = '1; pkt_rdy = 1'b1; frm_req = 1'b1;
        tick();
        frm_req = 1'b0;
        vecs++;
        if (ch_rdy !== 4'b0100) begin
            errs++; $display("FAIL single_rdy: rdy=%b, required 0100", ch_rdy);
        end
        tick();
        ch_vld = '0;
        vecs++;
        if (pkt_vld !== 1'b1 || pkt_ch !== 2'd2) begin
            errs++; $display("FAIL single_pkt: vld=%b ch=%0d, required 1/2", pkt_vld, pkt_ch);
        end
        tick();
        vecs++;
        if (ch_rdy !== 4'b0000 || frm_done !== 1'b0) begin
            errs++; $display("FAIL single_arb2: rdy=%b done=%b, required 0000/0", ch_rdy, frm_done);
        end
        tick();
        vecs++;
        if (frm_done !== 1'b1 || frm_empty !== 1'b0) begin
            errs++; $display("FAIL single_done: done=%b empty=%b, required 1/0", frm_done, frm_empty);
        end
    endtask

    task automatic test_stall();
        ch_vld = '1; rcfc = '1; pkt_rdy = 1'b0; set_data(0); frm_req = 1'b1;
        tick();
        frm_req = 1'b0;
        vecs++;
        if (ch_rdy !== 4'b1000) begin
            errs++; $display("FAIL stall_rdy: rdy=%b, required 1000", ch_rdy);
        end
        tick();
        for (int s = 0; s < 5; s++) begin
            set_data(s + 1);
            rcfc = (s % 2 == 0) ? 4'b0000 : 4'b0101;
            vecs++;
            if (pkt_vld !== 1'b1 || pkt_ch !== 2'd3 || pkt_data !== pat(3, 0) || ch_rdy !== 4'b0000) begin
                errs++; $display("FAIL stall_hold%0d: vld=%b ch=%0d data=%h rdy=%b, required 1/3/%h/0000",
                                 s, pkt_vld, pkt_ch, pkt_data, ch_rdy, pat(3, 0));
            end
            tick();
        end
        pkt_rdy = 1'b1; ch_vld = '0; rcfc = '1;
        tick();
        vecs++;
        if (pkt_vld !== 1'b0 || ch_rdy !== 4'b0000) begin
            errs++; $display("FAIL stall_release: vld=%b rdy=%b, required 0/0000", pkt_vld, ch_rdy);
        end
        tick();
        vecs++;
        if (frm_done !== 1'b1) begin
            errs++; $display("FAIL stall_done: done=%b, required 1", frm_done);
        end
    endtask

    task automatic test_reset_mid();
        ch_vld = '1; rcfc = '1; pkt_rdy = 1'b0; set_data(0); frm_req = 1'b1;
        tick();
        frm_req = 1'b0;
        tick();
        vecs++;
        if (pkt_vld !== 1'b1 || pkt_ch !== 2'd0) begin
            errs++; $display("FAIL rstmid_pre: vld=%b ch=%0d, required 1/0", pkt_vld, pkt_ch);
        end
        rst_n = 1'b0;
        #2;
        vecs++;
        if (pkt_vld !== 1'b0 || pkt_data !== '0 || ch_rdy !== 4'b0000) begin
            errs++; $display("FAIL rstmid_async: vld=%b data=%h rdy=%b, required 0/0/0000", pkt_vld, pkt_data, ch_rdy);
        end
`ifdef SPIO_HSS_SCHED_STATS_EN
        vecs++;
        if (stat_cnt !== 16'd0) begin
            errs++; $display("FAIL stat_reset: cnt=%0d, required 0", stat_cnt);
        end
`endif
        #2;
        rst_n = 1'b1;
        tick();
        frm_req = 1'b1;
        tick();
        frm_req = 1'b0;
        vecs++;
        if (ch_rdy !== 4'b0001) begin
            errs++; $display("FAIL rstmid_first: rdy=%b, required 0001", ch_rdy);
        end
        tick();
        pkt_rdy = 1'b1; ch_vld = '0;
        tick();
        tick();
        vecs++;
        if (frm_done !== 1'b1) begin
            errs++; $display("FAIL rstmid_done: done=%b, required 1", frm_done);
        end
    endtask

`ifdef SPIO_HSS_SCHED_STATS_EN
    task automatic test_stats();
        stat_sel = 2'd0;
        #1;
        vecs++;
        if (stat_cnt !== 16'd1) begin
            errs++; $display("FAIL stat_count: cnt=%0d, required 1", stat_cnt);
        end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        vecs++;
        if (stat_cnt !== 16'd0) begin
            errs++; $display("FAIL stat_clear: cnt=%0d, required 0", stat_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_empty();
        test_round_robin();
        test_rcfc_mask();
        test_single();
        test_stall();
        test_reset_mid();
`ifdef SPIO_HSS_SCHED_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/spio_hss_multiplexer_pkt_sched.md
Name: spio_hss_multiplexer_pkt_sched

Overview:
- Transmit-side scheduler between the per-channel packet dispatch FIFOs and the frame assembler.
- On each frame request it pops up to MAX_PKTS packets from NUM_CH FIFOs, using round-robin order.
- Only channels whose remote peer advertises space (received per-channel cfcf bits) are eligible.
- Delivers packets one at a time, tagged with their channel id, over a valid/ready interface.

Parameters:
- NUM_CH, 4, number of packet FIFOs/channels (power of two, >=2).
- CH_BITS, 2, log2(NUM_CH).
- PKT_W, 72, packet width; must equal `PKT_BITS.
- MAX_PKTS, 4, maximum packets delivered per frame (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- frm_req  in  1  assembler requests contents for one frame; sampled only in IDLE.
- frm_done  out  1  one-cycle pulse: frame contents complete (>=1 packet sent).
- frm_empty  out  1  one-cycle pulse: frame request found no eligible channel.
- ch_vld  in  NUM_CH  per-FIFO packet valid.
- ch_data  in  NUM_CH*PKT_W  per-FIFO packet data; channel i occupies bits [i*PKT_W +: PKT_W].
- ch_rdy  out  NUM_CH  one-hot pop strobe to the winning FIFO.
- rcfc  in  NUM_CH  remote channel flow control; 1 = peer can accept a packet.
- pkt_data  out  PKT_W  selected packet, registered.
- pkt_ch  out  CH_BITS  channel id of pkt_data.
- pkt_vld  out  1  packet valid.
- pkt_rdy  in  1  assembler accepts packet.

Behaviour:
- Reset values: all outputs 0; state = IDLE; rr_ptr = NUM_CH-1, so channel 0 has first priority; pkt_cnt = 0.
- State IDLE: when frm_req=1, go to ARB and clear pkt_cnt; otherwise remain in IDLE.
- State ARB: eligible = ch_vld & rcfc.
  - eligible != 0: the winner is the first set bit scanning upward from rr_ptr+1, modulo NUM_CH.
    - Same cycle: ch_rdy[winner]=1 (combinational, single cycle).
    - Next edge: pkt_data <= ch_data[winner], pkt_ch <= winner, pkt_vld <= 1, rr_ptr <= winner; go to XFER.
  - eligible == 0 and pkt_cnt == 0: pulse frm_empty, go to IDLE.
  - eligible == 0 and pkt_cnt > 0: pulse frm_done, go to IDLE.
- State XFER: hold pkt_data, pkt_ch and pkt_vld stable until pkt_rdy=1.
  - On handshake: pkt_vld <= 0 and pkt_cnt <= pkt_cnt+1.
  - If pkt_cnt+1 == MAX_PKTS: pulse frm_done, go to IDLE. Otherwise go to ARB.
- ch_rdy is asserted only in ARB with eligible != 0; never more than one bit set.
- Latency: frm_req to first pkt_vld = 2 cycles; back-to-back packets at best 1 per 2 cycles (XFER -> ARB -> XFER).
- rcfc or ch_vld changing while in XFER does not affect the held packet; both are re-sampled only in ARB.
- frm_req is ignored outside IDLE. frm_done and frm_empty are mutually exclusive and never asserted together with ch_rdy.
- rr_ptr wraps modulo NUM_CH; pkt_cnt width is clog2(MAX_PKTS+1).
- Reset mid-frame: all state is cleared asynchronously. A packet held in pkt_data is discarded because its FIFO was already popped. This loss is accepted; the link-level retry covers it.

Optional Feature:
- Macro: SPIO_HSS_SCHED_STATS_EN.
- Defined:
  - Adds inputs stat_sel (CH_BITS) and stat_clr (1), and output stat_cnt (16).
  - Per-channel 16-bit grant counters, incremented on each ch_rdy, saturating at 0xFFFF.
  - stat_cnt = counter[stat_sel], combinational.
  - stat_clr zeroes all counters synchronously. If stat_clr and an increment occur in the same cycle, the clear wins.
  - Counters reset to 0.
- Undefined: the ports and counters do not exist; scheduling behaviour is identical.

Decomposition:
- Shared header spio_hss_multiplexer_common.h gets `PKT_BITS (existing) and the scheduler state encodings SCHED_IDLE=2'd0, SCHED_ARB=2'd1, SCHED_XFER=2'd2.
- One sub-module: spio_hss_multiplexer_rr_arb.
  - Purely combinational.
  - Inputs: req vector and rr_ptr. Outputs: one-hot gnt and binary gnt_id.
  - Reusable by the receive-side dispatcher.

Test Plan:
- Reset, then frm_req with ch_vld=4'b0000: frm_empty pulses 2 cycles after frm_req; no ch_rdy; pkt_vld stays 0.
- All channels valid, rcfc=4'b1111, pkt_rdy=1, MAX_PKTS=4: pkt_ch sequence 0,1,2,3; frm_done after 4th handshake; next frame starts at ch 0.
- ch_vld=4'b1111, rcfc=4'b1010: only channels 1 and 3 are granted, in alternation; channels 0 and 2 see no ch_rdy.
- Only ch 2 valid with 1 packet, MAX_PKTS=4: one packet delivered, then frm_done with pkt_cnt=1; no frm_empty.
- pkt_rdy held low 5 cycles while ch_data and rcfc toggle: pkt_data and pkt_ch are stable for the whole stall; exactly one ch_rdy pulse.
- rst_n asserted during XFER: pkt_vld drops immediately (asynchronous); after release, frm_req grants ch 0 first. With SPIO_HSS_SCHED_STATS_EN defined, counters read 0 after reset and saturate at 0xFFFF under a forced long run.
